voice_bank: RTL and testbench
=============================

// Module: voice_bank
// PURPOSE
// 16-voice oscillator bank directly upstream of the wave summing/averaging stage. One phase
// accumulator per voice, time-multiplexed through one adder, swept once per sample tick.
// Emits one 6-bit waveform per voice plus the latched playing mask. Non-playing voices are
// forced to 0 so the downstream sum and voice count stay consistent.
// PARAMETERS
// NUM_VOICES  16    voices; fixed 16 to match the 16-bit playing mask downstream
// PHASE_W     16    phase accumulator and tuning word width
// WAVE_W      6     output sample width per voice
// SAMPLE_DIV  1000  clk cycles per sample tick; must be > NUM_VOICES+1
// PORTS
// clk          in   1          system clock; sole clock domain
// reset        in   1          synchronous, active-high reset
// playing_in   in   16         note-held mask from pad decoder, bit i = voice i
// shape        in   2          global shape: 0 saw, 1 square, 2 triangle, 3 saw
// tune_wr      in   1          tuning write strobe, one cycle
// tune_addr    in   4          voice index for tuning write
// tune_data    in   PHASE_W    phase increment per sample tick
// waves        out  16*WAVE_W  voice i at [i*WAVE_W +: WAVE_W]; feeds wave0..wave15
// playing      out  16         mask latched at sweep start; feeds the adder mask
// sample_valid out  1          one-cycle pulse: all waves/playing coherent for new sample
// overrun      out  1          sticky: a tick arrived while a sweep was still running
// BEHAVIOUR
// - Reset (sync, clk edge with reset=1): all phases, tuning words, waves, playing,
//   sample_valid, overrun, tick counter = 0; FSM -> IDLE. Applies mid-sweep; sweep abandoned.
// - Tick counter 0..SAMPLE_DIV-1, wraps; tick asserted for one cycle when count = SAMPLE_DIV-1.
// - FSM IDLE: on tick latch playing_in into pm_lat, voice index v=0, -> SWEEP.
// - FSM SWEEP: one voice per cycle, v=0..15; at v=15 -> DONE. DONE: one cycle -> IDLE.
// - Per-voice update in SWEEP cycle for v:
//     pm_lat[v]=1: phase[v] <= phase[v] + tune[v] (mod 2^PHASE_W, wraps silently)
//     pm_lat[v]=0: phase[v] <= 0 (note-on always starts from phase 0)
//   wave shadow s[v] computed from the NEW phase value ph, p = ph[PHASE_W-1 -: WAVE_W]:
//     saw: p;  square: ph[MSB] ? 6'd63 : 6'd0;
//     triangle: ph[MSB] ? ~ph[MSB-1 -: WAVE_W] : ph[MSB-1 -: WAVE_W];
//     pm_lat[v]=0 -> s[v]=0 regardless of shape.
// - DONE cycle: waves <= all shadows, playing <= pm_lat, together; sample_valid <= 1 for
//   exactly that one following cycle. waves/playing otherwise hold (no mid-sweep tearing).
// - Latency: tick at cycle T -> voice v updated at T+1+v -> waves/playing/sample_valid
//   visible at T+18.
// - shape sampled per voice at its update cycle; change mid-sweep may mix shapes in one
//   sample (accepted; software changes shape between samples).
// - tune_wr: writes tune[tune_addr] at clk edge, any state. If written the same cycle voice
//   tune_addr is updated, the OLD increment is used; new one applies from next sample.
// - Tick while not IDLE: tick ignored, overrun <= 1 (sticky until reset). Unreachable when
//   SAMPLE_DIV > NUM_VOICES+1; flag exists for parameter misuse.
// - playing_in changes outside sweep start have no effect until next tick.
// - All outputs registered; no combinational path input -> output.
// TESTING
// 1 Reset: hold reset 3 cycles -> waves=0, playing=0, sample_valid=0, overrun=0; release,
//   first sample_valid exactly SAMPLE_DIV+17 cycles after release (tick at count 999).
// 2 Saw: tune[0]=16'h0400, playing_in=16'h0001, shape=0 -> wave0 = 1,2,3.. per sample;
//   after 64 samples wraps to 0; all other waves 0, playing=16'h0001.
// 3 Square/triangle: tune[3]=16'h2000, shape=1 -> wave3 0,0,0,63,63,63,63,0; shape=2,
//   tune[3]=16'h0200 -> wave3 1,2,..,63, then 63,62,... (8 tri steps/wrap checked).
// 4 Note-off/on: voice 5 playing, release bit 5 -> next sample wave5=0; re-press -> first
//   sample wave5 equals value for phase=tune[5] (restarts from 0).
// 5 Tune write collision: tune_wr to voice 7 on voice 7's sweep cycle -> that sample uses
//   old increment, next sample new; write during IDLE takes effect at next sweep.
// 6 Reset mid-sweep at v=8, and SAMPLE_DIV=10 build -> waves stay 0 after reset, no
//   sample_valid from abandoned sweep; SAMPLE_DIV=10 run sets overrun=1 and it stays set.

Source files
------------

// File: rtl/voice_bank_if.sv
// Control and sample bus between the voice bank and its neighbours.
// master drives tuning/mask/shape, slave returns per-voice waves.
interface voice_bank_if #(
    parameter int PHASE_W = 16,
    parameter int WAVE_W  = 6
);
    logic [15:0]          playing_in;
    logic [1:0]           shape;
    logic                 tune_wr;
    logic [3:0]           tune_addr;
    logic [PHASE_W-1:0]   tune_data;
    logic [16*WAVE_W-1:0] waves;
    logic [15:0]          playing;
    logic                 sample_valid;
    logic                 overrun;

    modport master (
        output playing_in, shape, tune_wr, tune_addr, tune_data,
        input  waves, playing, sample_valid, overrun
    );

    modport slave (
        input  playing_in, shape, tune_wr, tune_addr, tune_data,
        output waves, playing, sample_valid, overrun
    );
endinterface

// File: rtl/voice_bank.sv
// 16-voice phase-accumulator oscillator bank, one shared adder swept
// once per sample tick; results published together after the sweep.
module voice_bank #(
    parameter int NUM_VOICES = 16,
    parameter int PHASE_W    = 16,
    parameter int WAVE_W     = 6,
    parameter int SAMPLE_DIV = 1000
) (
    input logic        clk,
    input logic        reset,
    voice_bank_if.slave bus
);
    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int MSB   = PHASE_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic [3:0]         v;
    logic [15:0]        pm_lat;
    logic [PHASE_W-1:0] phase  [NUM_VOICES];
    logic [PHASE_W-1:0] tune   [NUM_VOICES];
    logic [WAVE_W-1:0]  shadow [NUM_VOICES];

    logic [16*WAVE_W-1:0] waves_q;
    logic [16*WAVE_W-1:0] wave_pack;
    logic [15:0]          playing_q;
    logic                 valid_q;
    logic                 overrun_q;

    logic [PHASE_W-1:0] ph_new;
    logic [WAVE_W-1:0]  wave_new;

    assign tick = (cnt == CNT_W'(SAMPLE_DIV - 1));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (tick) state_nx = SWEEP;
            SWEEP:   if (v == 4'(NUM_VOICES - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Released voices restart from phase 0 so note-on is deterministic.
    always_comb begin
        ph_new   = pm_lat[v] ? phase[v] + tune[v] : '0;
        wave_new = '0;
        unique case (bus.shape)
            2'd1: wave_new = ph_new[MSB] ? '1 : '0;
            2'd2: wave_new = ph_new[MSB] ? ~ph_new[MSB-1 -: WAVE_W]
                                         :  ph_new[MSB-1 -: WAVE_W];
            default: wave_new = ph_new[MSB -: WAVE_W];
        endcase
        if (!pm_lat[v]) wave_new = '0;
    end

    always_comb begin
        wave_pack = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            wave_pack[i*WAVE_W +: WAVE_W] = shadow[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            v         <= '0;
            pm_lat    <= '0;
            waves_q   <= '0;
            playing_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i]  <= '0;
                tune[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            state   <= state_nx;
            cnt     <= tick ? '0 : cnt + 1'b1;
            valid_q <= (state == DONE);
            if (bus.tune_wr) tune[bus.tune_addr] <= bus.tune_data;
            if (tick && state != IDLE) overrun_q <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        pm_lat <= bus.playing_in;
                        v      <= '0;
                    end
                end
                SWEEP: begin
                    phase[v]  <= ph_new;
                    shadow[v] <= wave_new;
                    v         <= v + 1'b1;
                end
                DONE: begin
                    waves_q   <= wave_pack;
                    playing_q <= pm_lat;
                end
                default: ;
            endcase
        end
    end

    assign bus.waves        = waves_q;
    assign bus.playing      = playing_q;
    assign bus.sample_valid = valid_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_voice_bank.sv
// Directed bench for voice_bank: reference model pushes expected samples
// into a queue, each sample_valid pops and compares.
module tb_voice_bank;
    localparam int DIV = 40;
    localparam int BUDGET = 2 * DIV + 20;

    logic clk = 1'b0;
    logic reset;
    logic reset2;

    always #5 clk = ~clk;

    voice_bank_if #(.PHASE_W(16), .WAVE_W(6)) bus ();
    voice_bank_if #(.PHASE_W(16), .WAVE_W(6)) bus2 ();

    voice_bank #(.SAMPLE_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    voice_bank #(.SAMPLE_DIV(10)) dut2 (
        .clk(clk), .reset(reset2), .bus(bus2.slave)
    );

    typedef struct packed {
        logic [95:0] w;
        logic [15:0] p;
    } exp_t;

    exp_t        q[$];
    logic [15:0] ph_m[16];
    logic [15:0] tune_m[16];
    int          n_assert = 0;
    int          n_fail = 0;
    int          lat;
    logic        bad;

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] wave_of(input logic [15:0] ph,
                                           input logic [1:0] sh);
        case (sh)
            2'd1:    return ph[15] ? 6'd63 : 6'd0;
            2'd2:    return ph[15] ? ~ph[14:9] : ph[14:9];
            default: return ph[15:10];
        endcase
    endfunction

    task automatic model_push();
        exp_t e;
        e.w = '0;
        e.p = bus.playing_in;
        for (int i = 0; i < 16; i++) begin
            if (bus.playing_in[i]) begin
                ph_m[i] = ph_m[i] + tune_m[i];
                e.w[i*6 +: 6] = wave_of(ph_m[i], bus.shape);
            end else begin
                ph_m[i] = '0;
            end
        end
        q.push_back(e);
    endtask

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < 16; i++) begin
            ph_m[i]   = '0;
            tune_m[i] = '0;
        end
    endtask

    task automatic sample_check(input string tag, output int n);
        exp_t e;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.sample_valid && n < BUDGET);
        if (!bus.sample_valid) begin
            chk({tag, "_timeout"}, 96'(bus.sample_valid), 96'd1);
        end else if (q.size() == 0) begin
            chk({tag, "_unexpected"}, 96'(bus.sample_valid), 96'd0);
        end else begin
            e = q.pop_front();
            chk({tag, "_waves"}, bus.waves, e.w);
            chk({tag, "_playing"}, 96'(bus.playing), 96'(e.p));
        end
    endtask

    task automatic tune_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.tune_wr   = 1'b1;
        bus.tune_addr = a;
        bus.tune_data = d;
        @(negedge clk);
        bus.tune_wr = 1'b0;
        tune_m[a] = d;
    endtask

    function automatic logic [5:0] wv(input int i);
        logic [95:0] w;
        w = bus.waves;
        return w[i*6 +: 6];
    endfunction

    initial begin
        reset  = 1'b1;
        reset2 = 1'b1;
        bus.playing_in = '0;
        bus.shape      = '0;
        bus.tune_wr    = 1'b0;
        bus.tune_addr  = '0;
        bus.tune_data  = '0;
        bus2.playing_in = 16'hffff;
        bus2.shape      = '0;
        bus2.tune_wr    = 1'b0;
        bus2.tune_addr  = '0;
        bus2.tune_data  = '0;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_waves", bus.waves, '0);
        chk("rst_playing", 96'(bus.playing), '0);
        chk("rst_valid", 96'(bus.sample_valid), '0);
        chk("rst_overrun", 96'(bus.overrun), '0);
        chk("rst_overrun2", 96'(bus2.overrun), '0);
        reset  = 1'b0;
        reset2 = 1'b0;

        model_push();
        sample_check("first", lat);
        chk("first_latency", 96'(lat), 96'(DIV + 17));

        tune_write(4'd0, 16'h0400);
        bus.playing_in = 16'h0001;
        bus.shape      = 2'd0;
        for (int i = 1; i <= 66; i++) begin
            model_push();
            sample_check("saw", lat);
            chk("saw_wave0", 96'(wv(0)), 96'(i % 64));
        end
        chk("overrun2_set", 96'(bus2.overrun), 96'd1);

        tune_write(4'd3, 16'h2000);
        bus.playing_in = 16'h0008;
        bus.shape      = 2'd1;
        for (int k = 1; k <= 8; k++) begin
            model_push();
            sample_check("square", lat);
            chk("square_wave3", 96'(wv(3)),
                (k >= 4 && k <= 7) ? 96'd63 : 96'd0);
        end

        tune_write(4'd3, 16'h0200);
        bus.shape = 2'd2;
        for (int k = 1; k <= 66; k++) begin
            model_push();
            sample_check("tri", lat);
            chk("tri_wave3", 96'(wv(3)), (k < 64) ? 96'(k) : 96'(127 - k));
        end

        tune_write(4'd5, 16'h1234);
        bus.playing_in = 16'h0020;
        bus.shape      = 2'd0;
        model_push();
        sample_check("note1", lat);
        chk("note1_wave5", 96'(wv(5)), 96'd4);
        model_push();
        sample_check("note2", lat);
        chk("note2_wave5", 96'(wv(5)), 96'd9);
        bus.playing_in = 16'h0000;
        model_push();
        sample_check("noteoff", lat);
        chk("noteoff_wave5", 96'(wv(5)), 96'd0);
        bus.playing_in = 16'h0020;
        model_push();
        sample_check("noteon", lat);
        chk("noteon_wave5", 96'(wv(5)), 96'd4);

        tune_write(4'd7, 16'h0800);
        bus.playing_in = 16'h0080;
        model_push();
        sample_check("idlewr", lat);
        chk("idlewr_wave7", 96'(wv(7)), 96'd2);
        // land the write on the edge that updates voice 7
        model_push();
        repeat (DIV - 9) @(negedge clk);
        bus.tune_wr   = 1'b1;
        bus.tune_addr = 4'd7;
        bus.tune_data = 16'h1000;
        @(negedge clk);
        bus.tune_wr = 1'b0;
        tune_m[7] = 16'h1000;
        sample_check("collide", lat);
        chk("collide_wave7", 96'(wv(7)), 96'd4);
        model_push();
        sample_check("postcol", lat);
        chk("postcol_wave7", 96'(wv(7)), 96'd8);

        bus.playing_in = 16'hffff;
        model_push();
        sample_check("full", lat);
        repeat (DIV - 8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        bad = 1'b0;
        repeat (DIV + 10) begin
            @(posedge clk);
            #1;
            if (bus.sample_valid || bus.waves != '0) bad = 1'b1;
        end
        chk("abandoned_sweep", 96'(bad), 96'd0);
        chk("midrst_playing", 96'(bus.playing), '0);
        model_push();
        sample_check("after_rst", lat);
        chk("overrun_main", 96'(bus.overrun), '0);
        chk("overrun2_sticky", 96'(bus2.overrun), 96'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
